if_fetch: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register. It produces the PC/instruction pair consumed by the decode stage and consumes decode's branch-redirect outputs (take-branch, jump PC).
- It drives a req/ack instruction-memory port with arbitrary wait states. It honours decode-stage stalls through a one-entry skid buffer.
- It implements the MIPS single delay slot: the instruction after a taken branch/jump always issues, then fetch continues at the target.

---
 rtl/if_fetch_if.sv | 32 +++
 rtl/if_fetch.sv | 141 ++++++++++++++
 tb/tb_if_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Purpose: bundles the fetch stage's instruction-memory port and its decode-side
//          signals (stall, redirect, IF/ID outputs) into one interface.
// Signals:
//   i_stall, i_takeBranch, i_jpc     decode/hazard unit -> fetch
//   o_imemReq, o_imemAddr            fetch -> instruction memory
//   i_imemAck, i_imemData            instruction memory -> fetch
//   o_pc, o_inst, o_valid            IF/ID register -> decode
// Modports: master = fetch stage view, slave = environment (memory + decode) view.
interface if_fetch_if #(
   parameter int unsigned INST_W = 32
) ();
   logic              i_stall;
   logic              i_takeBranch;
   logic [INST_W-1:0] i_jpc;
   logic              o_imemReq;
   logic [INST_W-1:0] o_imemAddr;
   logic              i_imemAck;
   logic [INST_W-1:0] i_imemData;
   logic [INST_W-1:0] o_pc;
   logic [INST_W-1:0] o_inst;
   logic              o_valid;

   modport master (
      input  i_stall, i_takeBranch, i_jpc, i_imemAck, i_imemData,
      output o_imemReq, o_imemAddr, o_pc, o_inst, o_valid
   );

   modport slave (
      output i_stall, i_takeBranch, i_jpc, i_imemAck, i_imemData,
      input  o_imemReq, o_imemAddr, o_pc, o_inst, o_valid
   );
endinterface

// File: rtl/if_fetch.sv
// Purpose: MIPS instruction-fetch stage with IF/ID pipeline register, req/ack
//          instruction-memory port, one-entry skid buffer for decode stalls and
//          single-delay-slot branch redirect handling.
// Ports:
//   i_clk   clock, rising edge
//   i_rstn  asynchronous active-low reset
//   bus     if_fetch_if.master: memory request/ack, decode stall/redirect, IF/ID outputs
module if_fetch #(
   parameter int unsigned          INST_W   = 32,
   parameter logic [INST_W-1:0]    RESET_PC = '0
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   if_fetch_if.master bus
);

   localparam logic [INST_W-1:0] PC_STEP = INST_W'(4);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [INST_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              valid_q, valid_d;
   logic [INST_W-1:0] skid_pc_q, skid_pc_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic              pend_valid_q, pend_valid_d;
   logic [INST_W-1:0] pend_target_q, pend_target_d;

   logic              consume;
   logic              slot_free;
   logic              redirect;
   logic              ack;
   logic [INST_W-1:0] seq_pc;

   // State and pipeline registers
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q       <= S_FETCH;
         req_q         <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         pc_q          <= '0;
         inst_q        <= '0;
         valid_q       <= 1'b0;
         skid_pc_q     <= '0;
         skid_inst_q   <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         fetch_pc_q    <= fetch_pc_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         valid_q       <= valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_inst_q   <= skid_inst_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Next-state: fetch sequencing, IF/ID/skid transfers and redirect tracking
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      valid_d       = valid_q;
      skid_pc_d     = skid_pc_q;
      skid_inst_d   = skid_inst_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;

      consume   = valid_q & ~bus.i_stall;
      slot_free = ~valid_q | consume;
      redirect  = consume & bus.i_takeBranch;
      // Ack only counts against a live request (first cycle after reset has none).
      ack       = req_q & bus.i_imemAck;
      // A pending redirect replaces the sequential successor of the delay slot.
      seq_pc    = pend_valid_q ? pend_target_q : (fetch_pc_q + PC_STEP);

      unique case (state_q)
         S_FETCH: begin
            if (ack) begin
               pend_valid_d = 1'b0;
               if (slot_free) begin
                  pc_d       = fetch_pc_q;
                  inst_d     = bus.i_imemData;
                  valid_d    = 1'b1;
                  // Delay slot lands this edge, so the redirect takes effect now.
                  fetch_pc_d = redirect ? bus.i_jpc : seq_pc;
               end else begin
                  skid_pc_d   = fetch_pc_q;
                  skid_inst_d = bus.i_imemData;
                  fetch_pc_d  = seq_pc;
                  state_d     = S_HOLD;
               end
            end else begin
               if (consume) begin
                  pc_d    = '0;
                  inst_d  = '0;
                  valid_d = 1'b0;
               end
               // Delay slot still in flight: keep the address stable, remember target.
               if (redirect) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = bus.i_jpc;
               end
            end
         end
         S_HOLD: begin
            if (consume) begin
               pc_d    = skid_pc_q;
               inst_d  = skid_inst_q;
               valid_d = 1'b1;
               state_d = S_FETCH;
               // Skid holds the delay slot; fetch_pc already moved past it.
               if (redirect) begin
                  fetch_pc_d = bus.i_jpc;
               end
            end
         end
         default: state_d = S_FETCH;
      endcase

      req_d = (state_d == S_FETCH);
   end

   assign bus.o_imemReq  = req_q;
   assign bus.o_imemAddr = fetch_pc_q;
   assign bus.o_pc       = pc_q;
   assign bus.o_inst     = inst_q;
   assign bus.o_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Purpose: directed self-checking bench for if_fetch with a wait-state
//          instruction-memory model returning addr | 32'hA000_0000.
module tb_if_fetch;

   logic       clk;
   logic       rstn;
   logic [3:0] waits;
   logic [3:0] wcnt;
   int         n_checks;
   int         n_errors;

   if_fetch_if #(.INST_W(32)) bus ();

   if_fetch #(.INST_W(32), .RESET_PC(32'h0000_0000)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack after 'waits' stalled cycles of an outstanding request
   assign bus.i_imemAck  = bus.o_imemReq && (wcnt == waits);
   assign bus.i_imemData = bus.o_imemAddr | 32'hA000_0000;

   always @(posedge clk) begin
      if (bus.o_imemReq && !bus.i_imemAck) wcnt <= wcnt + 4'd1;
      else                                 wcnt <= 4'd0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] w);
      rstn             = 1'b0;
      waits            = w;
      bus.i_stall      = 1'b0;
      bus.i_takeBranch = 1'b0;
      bus.i_jpc        = 32'h0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wait_pc(input logic [31:0] target);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (bus.o_valid && bus.o_pc == target) begin
            found = 1'b1;
            break;
         end
      end
      check("wait_pc_timeout", 32'(found), 32'd1);
   endtask

   task automatic wait_addr(input logic [31:0] target);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (bus.o_imemReq && bus.o_imemAddr == target) begin
            found = 1'b1;
            break;
         end
      end
      check("wait_addr_timeout", 32'(found), 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      wcnt     = 4'd0;

      // Zero-wait streaming
      do_reset(4'd0);
      check("rst_req",   32'(bus.o_imemReq), 32'd0);
      check("rst_valid", 32'(bus.o_valid),   32'd0);
      check("rst_pc",    bus.o_pc,           32'h0);
      check("rst_inst",  bus.o_inst,         32'h0);
      cyc();
      check("s1_req",   32'(bus.o_imemReq), 32'd1);
      check("s1_addr",  bus.o_imemAddr,     32'h0);
      check("s1_valid", 32'(bus.o_valid),   32'd0);
      cyc();
      check("s2_addr",  bus.o_imemAddr, 32'h4);
      check("s2_valid", 32'(bus.o_valid), 32'd1);
      check("s2_pc",    bus.o_pc,   32'h0);
      check("s2_inst",  bus.o_inst, 32'hA000_0000);
      cyc();
      check("s3_addr", bus.o_imemAddr, 32'h8);
      check("s3_pc",   bus.o_pc,   32'h4);
      check("s3_inst", bus.o_inst, 32'hA000_0004);
      cyc();
      check("s4_addr", bus.o_imemAddr, 32'hC);
      check("s4_pc",   bus.o_pc,   32'h8);

      // Three wait states
      do_reset(4'd3);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("w3_addr_hold", bus.o_imemAddr, 32'h0);
         check("w3_req_hold",  32'(bus.o_imemReq), 32'd1);
         check("w3_no_valid",  32'(bus.o_valid), 32'd0);
      end
      cyc();
      check("w3_v0",    32'(bus.o_valid), 32'd1);
      check("w3_pc0",   bus.o_pc,   32'h0);
      check("w3_inst0", bus.o_inst, 32'hA000_0000);
      check("w3_addr4", bus.o_imemAddr, 32'h4);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("w3_bubble_valid", 32'(bus.o_valid), 32'd0);
         check("w3_bubble_inst",  bus.o_inst, 32'h0);
      end
      cyc();
      check("w3_v1",  32'(bus.o_valid), 32'd1);
      check("w3_pc1", bus.o_pc, 32'h4);

      // Decode stall with skid capture
      do_reset(4'd0);
      cyc();
      cyc();
      check("st_pc0", bus.o_pc, 32'h0);
      bus.i_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("st_req_low",  32'(bus.o_imemReq), 32'd0);
         check("st_pc_frozen", bus.o_pc, 32'h0);
         check("st_valid",    32'(bus.o_valid), 32'd1);
      end
      bus.i_stall = 1'b0;
      cyc();
      check("st_rel_pc",   bus.o_pc,   32'h4);
      check("st_rel_inst", bus.o_inst, 32'hA000_0004);
      check("st_rel_req",  32'(bus.o_imemReq), 32'd1);
      check("st_rel_addr", bus.o_imemAddr, 32'h8);
      cyc();
      check("st_pc8", bus.o_pc, 32'h8);
      cyc();
      check("st_pcC",   bus.o_pc,   32'hC);
      check("st_instC", bus.o_inst, 32'hA000_000C);

      // Branch at 0x10, zero-wait
      do_reset(4'd0);
      wait_pc(32'h10);
      check("br0_addr", bus.o_imemAddr, 32'h14);
      bus.i_takeBranch = 1'b1;
      bus.i_jpc        = 32'h100;
      cyc();
      bus.i_takeBranch = 1'b0;
      check("br0_slot_pc", bus.o_pc, 32'h14);
      check("br0_tgt_addr", bus.o_imemAddr, 32'h100);
      cyc();
      check("br0_tgt_pc",   bus.o_pc,   32'h100);
      check("br0_tgt_inst", bus.o_inst, 32'hA000_0100);
      cyc();
      check("br0_tgt4_pc", bus.o_pc, 32'h104);

      // Branch to top of address space: sequential fetch wraps to zero
      do_reset(4'd0);
      wait_pc(32'h10);
      bus.i_takeBranch = 1'b1;
      bus.i_jpc        = 32'hFFFF_FFF8;
      cyc();
      bus.i_takeBranch = 1'b0;
      check("wr_slot_pc", bus.o_pc, 32'h14);
      cyc();
      check("wr_pc_f8", bus.o_pc, 32'hFFFF_FFF8);
      cyc();
      check("wr_pc_fc",   bus.o_pc, 32'hFFFF_FFFC);
      check("wr_addr_0",  bus.o_imemAddr, 32'h0);
      cyc();
      check("wr_pc_0",   bus.o_pc,   32'h0);
      check("wr_inst_0", bus.o_inst, 32'hA000_0000);

      // Branch at 0x10 with delay slot outstanding (2 wait states)
      do_reset(4'd2);
      wait_pc(32'h10);
      check("br2_addr", bus.o_imemAddr, 32'h14);
      bus.i_takeBranch = 1'b1;
      bus.i_jpc        = 32'h100;
      cyc();
      bus.i_takeBranch = 1'b0;
      check("br2_bubble", 32'(bus.o_valid), 32'd0);
      check("br2_addr_hold1", bus.o_imemAddr, 32'h14);
      cyc();
      check("br2_addr_hold2", bus.o_imemAddr, 32'h14);
      cyc();
      check("br2_slot_valid", 32'(bus.o_valid), 32'd1);
      check("br2_slot_pc",    bus.o_pc, 32'h14);
      check("br2_tgt_addr",   bus.o_imemAddr, 32'h100);
      cyc();
      check("br2_gap1", 32'(bus.o_valid), 32'd0);
      cyc();
      check("br2_gap2", 32'(bus.o_valid), 32'd0);
      cyc();
      check("br2_tgt_valid", 32'(bus.o_valid), 32'd1);
      check("br2_tgt_pc",    bus.o_pc, 32'h100);

      // Asynchronous reset while a request to 0x20 is waiting
      do_reset(4'd3);
      wait_addr(32'h20);
      check("ar_pre_valid", 32'(bus.o_valid), 32'd1);
      check("ar_pre_pc",    bus.o_pc, 32'h1C);
      #2;
      rstn = 1'b0;
      #1;
      check("ar_req",   32'(bus.o_imemReq), 32'd0);
      check("ar_valid", 32'(bus.o_valid), 32'd0);
      check("ar_pc",    bus.o_pc, 32'h0);
      check("ar_addr",  bus.o_imemAddr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      cyc();
      check("ar_rel_req",  32'(bus.o_imemReq), 32'd1);
      check("ar_rel_addr", bus.o_imemAddr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
